// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, resolves unconditional jumps locally
// and buffers all other instructions (with their PC) in a 2-entry FIFO
// toward decode.
//
// Handshake: an entry moves to decode on a rising edge where if_valid and
// if_ready are both 1. if_valid depends only on internal state and never on
// if_ready. if_instr/if_pc hold steady while if_valid=1 and no transfer has
// happened. Both read 0 while the FIFO is empty.
module fetch_unit #(
  parameter int ADDR_W     = 8,
  parameter int MEM_DEPTH  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] Read_Address,
  input  logic [7:0]        instruction,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [7:0]        if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [7:0]        jump_count,
  output logic [1:0]        fill_state
);

  // Occupancy summary exposed on fill_state.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // MEM_DEPTH is a power of two, so the modulo is a mask.
  localparam logic [ADDR_W-1:0] PC_MASK   = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [1:0]        FULL_CNT  = 2'(FIFO_DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [7:0]        instr_mem [2];
  logic [ADDR_W-1:0] pc_mem    [2];

  logic              is_jump;
  logic              fetch;
  logic              push;
  logic              jump_taken;
  logic              pop;
  logic [ADDR_W-1:0] jump_off;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jump_pc;

  // Fetch/jump decode. The full check uses the pre-pop count, so a pop never
  // frees a slot for a fetch in the same cycle.
  always_comb begin
    is_jump    = (instruction[7:6] == 2'b11);
    fetch      = fetch_en && !redirect_valid && (count != FULL_CNT);
    push       = fetch && !is_jump;
    jump_taken = fetch && is_jump;
    pop        = if_valid && if_ready;
    jump_off   = {{(ADDR_W-6){instruction[5]}}, instruction[5:0]};
    seq_pc     = (pc + ADDR_W'(1)) & PC_MASK;
    jump_pc    = (pc + ADDR_W'(1) + jump_off) & PC_MASK;
  end

  // FIFO payload storage; occupancy lives in the control block below.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem[wr_ptr] <= instruction;
      pc_mem[wr_ptr]    <= pc;
    end
  end

  // PC, FIFO pointers/count and jump counter. Reset beats redirect, which
  // beats normal fetch/pop activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      count      <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      jump_count <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_addr & PC_MASK;
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push)       pc <= seq_pc;
      if (jump_taken) begin
        pc         <= jump_pc;
        jump_count <= jump_count + 8'd1;
      end
    end
  end

  // Head presentation and occupancy summary.
  always_comb begin
    Read_Address = pc;
    if_valid     = (count != 2'd0);
    if_instr     = if_valid ? instr_mem[rd_ptr] : 8'd0;
    if_pc        = if_valid ? pc_mem[rd_ptr] : '0;
    case (count)
      2'd0:    fill_state = ST_EMPTY;
      2'd1:    fill_state = ST_PARTIAL;
      default: fill_state = ST_FULL;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// checked against a queue-based model of the fetch stage.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] read_address;
  logic [7:0] instruction;
  logic       fetch_en;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       if_valid;
  logic       if_ready;
  logic [7:0] if_instr;
  logic [7:0] if_pc;
  logic [7:0] jump_count;
  logic [1:0] fill_state;

  // Instruction memory answers combinationally.
  logic [7:0] imem [32];
  assign instruction = imem[read_address[4:0]];

  // Model state: PC, buffered {pc, instr} entries, jump counter.
  int          m_pc;
  int          m_jc;
  logic [15:0] exp_q [$];
  logic [15:0] delivered [$];

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(8), .MEM_DEPTH(32), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .Read_Address   (read_address),
    .instruction    (instruction),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .jump_count     (jump_count),
    .fill_state     (fill_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model's current state.
  task automatic check_outputs();
    logic [15:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 16'h0;
    check("if_valid",     32'(if_valid),     32'(exp_q.size() != 0));
    check("if_pc",        32'(if_pc),        32'(head[15:8]));
    check("if_instr",     32'(if_instr),     32'(head[7:0]));
    check("read_address", 32'(read_address), 32'(m_pc));
    check("jump_count",   32'(jump_count),   32'(m_jc));
    check("fill_state",   32'(fill_state),   32'(exp_q.size()));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    bit         do_fetch;
    bit         do_pop;
    logic [7:0] ins;
    int         off;
    do_fetch = fetch_en && !redirect_valid && (exp_q.size() < 2);
    do_pop   = (exp_q.size() != 0) && if_ready;
    if (reset) begin
      m_pc = 0;
      m_jc = 0;
      exp_q.delete();
    end else if (redirect_valid) begin
      exp_q.delete();
      m_pc = int'(redirect_addr) % 32;
    end else begin
      if (do_pop) delivered.push_back(exp_q.pop_front());
      if (do_fetch) begin
        ins = imem[m_pc];
        if (ins[7:6] == 2'b11) begin
          off  = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
          m_pc = (m_pc + 1 + off + 64) % 32;
          m_jc = (m_jc + 1) % 256;
        end else begin
          exp_q.push_back({8'(m_pc), ins});
          m_pc = (m_pc + 1) % 32;
        end
      end
    end
  endtask

  // One cycle: check, update model, clock, settle away from the edge.
  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 32; i++) imem[i] = 8'(i);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    delivered.delete();
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 8'h0; if_ready = 1'b0;
    m_pc = 0; m_jc = 0;
    fill_linear();
    @(posedge clk); #1;
    step();

    // Sequential fetch with a jump over address 2.
    imem[0] = 8'h49; imem[1] = 8'hC1; imem[2] = 8'h64; imem[3] = 8'hA9; imem[4] = 8'h5D;
    fetch_en = 1'b1; if_ready = 1'b1;
    do_reset();
    step();
    check("t1_first_valid", 32'(if_valid), 32'd1);
    check("t1_first_pc",    32'(if_pc),    32'd0);
    steps(7);
    check("t1_del0", 32'(delivered[0]), 32'h0049);
    check("t1_del1", 32'(delivered[1]), 32'h03A9);
    check("t1_del2", 32'(delivered[2]), 32'h045D);
    check("t1_jc",   32'(jump_count),   32'd1);

    // Back-pressure from reset.
    fill_linear();
    if_ready = 1'b0;
    do_reset();
    steps(4);
    check("t2_hold_addr", 32'(read_address), 32'd2);
    check("t2_full",      32'(fill_state),   32'd2);
    if_ready = 1'b1;
    steps(3);
    check("t2_del_n",  32'(delivered.size()), 32'd3);
    check("t2_del0",   32'(delivered[0][15:8]), 32'd0);
    check("t2_del1",   32'(delivered[1][15:8]), 32'd1);
    check("t2_del2",   32'(delivered[2][15:8]), 32'd2);

    // Modulo wrap: redirect to 31, jump +1 twice.
    imem[31] = 8'hC1; imem[1] = 8'hC1;
    do_reset();
    redirect_valid = 1'b1; redirect_addr = 8'd31;
    step();
    redirect_valid = 1'b0;
    step();
    check("t3_wrap_addr", 32'(read_address), 32'd1);
    steps(3);
    check("t3_jc",       32'(jump_count),       32'd2);
    check("t3_first_pc", 32'(delivered[0][15:8]), 32'd3);

    // Redirect with a full FIFO and a concurrent pop.
    fill_linear();
    if_ready = 1'b0;
    do_reset();
    steps(3);
    check("t4_full", 32'(fill_state), 32'd2);
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h04;
    step();
    redirect_valid = 1'b0;
    check("t4_flush_valid", 32'(if_valid),     32'd0);
    check("t4_addr",        32'(read_address), 32'd4);
    step();
    check("t4_valid_pc", 32'(if_pc),    32'd4);
    check("t4_valid",    32'(if_valid), 32'd1);

    // Jump-to-self halt with counter wrap.
    imem[5] = 8'hFF;
    do_reset();
    redirect_valid = 1'b1; redirect_addr = 8'd5;
    step();
    redirect_valid = 1'b0;
    steps(256);
    check("t5_jc_wrap", 32'(jump_count),   32'd0);
    check("t5_addr",    32'(read_address), 32'd5);
    check("t5_valid",   32'(if_valid),     32'd0);
    step();
    check("t5_jc_one", 32'(jump_count), 32'd1);

    // Mid-run reset with two entries buffered.
    fill_linear();
    if_ready = 1'b0;
    do_reset();
    steps(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_valid", 32'(if_valid),     32'd0);
    check("t6_pc",    32'(if_pc),        32'd0);
    check("t6_instr", 32'(if_instr),     32'd0);
    check("t6_addr",  32'(read_address), 32'd0);
    check("t6_jc",    32'(jump_count),   32'd0);
    step();
    check("t6_resume", 32'(if_pc), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 32; i++) imem[i] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 600; n++) begin
      fetch_en       = ($urandom_range(0, 99) < 80);
      if_ready       = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_addr  = 8'($urandom_range(0, 255));
      reset          = ($urandom_range(0, 99) < 2);
      if (n % 150 == 149)
        for (int i = 0; i < 32; i++) imem[i] = 8'($urandom_range(0, 255));
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
